// File: rtl/mod_n_down_counter.sv
// -----------------------------------------------------------------------------
// mod_n_down_counter
//
// Modulo-N down counter / timer. Counts N-1 down to 0, then either reloads
// N-1 and keeps running (periodic) or parks at 0 in DONE (one-shot). The mode
// is captured when start is pulsed. Event priority at each edge is
// rst > start > load > decrement.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   start     in   pulse: (re)start the countdown from N-1 and enter RUN
//   oneshot   in   mode sampled with start: 1 = one-shot, 0 = periodic
//   en        in   count enable; 0 pauses the count while in RUN
//   load      in   load load_val into q (clamped to N-1); state unchanged
//   load_val  in   [WIDTH-1:0] value for load
//   q         out  [WIDTH-1:0] current count (registered)
//   tc        out  terminal-count pulse, one cycle per expiry (registered)
//   zero      out  combinational (q == 0)
//   busy      out  high while in RUN (registered)
//   done      out  high while in DONE (registered)
// -----------------------------------------------------------------------------
module mod_n_down_counter #(
  parameter int N     = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             oneshot,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wrap/reload target; also the clamp ceiling for load_val.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             mode_q, mode_d;   // 1 = one-shot
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;

    if (start) begin
      q_d     = MAX_Q;
      mode_d  = oneshot;
      state_d = RUN;
    end else if (load) begin
      // load_val > N-1 is the same as load_val >= N.
      q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (state_q == RUN && en) begin
      if (q_q != '0) begin
        q_d = q_q - WIDTH'(1);
      end else begin
        // Expiry: q is already 0 on this edge, so tc lands one cycle after
        // q first shows 0 and the reload/stop happens together with it.
        tc_d = 1'b1;
        if (mode_q) begin
          state_d = DONE;
        end else begin
          q_d = MAX_Q;
        end
      end
    end

    // Status flags follow the next state so they change on the same edge.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= MAX_Q;
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = (q_q == '0);

endmodule

// File: tb/tb_mod_n_down_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_n_down_counter
//
// Directed bench for mod_n_down_counter. Three instances share the control
// inputs: N=5/WIDTH=3 (main behaviour), N=2/WIDTH=1 and the default N=4/WIDTH=2
// (boundary wrap). Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, so each sample reflects the last edge.
// -----------------------------------------------------------------------------
module tb_mod_n_down_counter;

  logic       clk = 1'b0;
  logic       rst, start, oneshot, en, load;
  logic [2:0] lv5;
  logic [0:0] lv2;
  logic [1:0] lv4;

  logic [2:0] q5;
  logic [0:0] q2;
  logic [1:0] q4;
  logic       tc5, zero5, busy5, done5;
  logic       tc2, zero2, busy2, done2;
  logic       tc4, zero4, busy4, done4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mod_n_down_counter #(.N(5), .WIDTH(3)) dut5 (
    .clk(clk), .rst(rst), .start(start), .oneshot(oneshot), .en(en),
    .load(load), .load_val(lv5), .q(q5), .tc(tc5), .zero(zero5),
    .busy(busy5), .done(done5)
  );

  mod_n_down_counter #(.N(2), .WIDTH(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .oneshot(oneshot), .en(en),
    .load(load), .load_val(lv2), .q(q2), .tc(tc2), .zero(zero2),
    .busy(busy2), .done(done2)
  );

  mod_n_down_counter dut4 (
    .clk(clk), .rst(rst), .start(start), .oneshot(oneshot), .en(en),
    .load(load), .load_val(lv4), .q(q4), .tc(tc4), .zero(zero4),
    .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full status check of the N=5 instance.
  task automatic chk5(input string tag, input int eq, input bit etc,
                      input bit ebusy, input bit edone);
    check({tag, ".q"},    32'(q5),    32'(eq));
    check({tag, ".tc"},   32'(tc5),   32'(etc));
    check({tag, ".busy"}, 32'(busy5), 32'(ebusy));
    check({tag, ".done"}, 32'(done5), 32'(edone));
    check({tag, ".zero"}, 32'(zero5), 32'(eq == 0));
  endtask

  // Expected q after each edge following start (periodic N=5).
  int per_q[11]  = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4, 3};
  // Expected q after each edge following start for N=2 and N=4.
  int n2_q[6]    = '{0, 1, 0, 1, 0, 1};
  int n4_q[6]    = '{2, 1, 0, 3, 2, 1};

  initial begin
    rst = 1'b1; start = 1'b0; oneshot = 1'b0; en = 1'b0; load = 1'b0;
    lv5 = '0; lv2 = '0; lv4 = '0;

    // ---- reset state
    tick();
    chk5("reset", 4, 0, 0, 0);

    // ---- periodic N=5
    rst = 1'b0; en = 1'b1; start = 1'b1; oneshot = 1'b0;
    tick();
    start = 1'b0;
    chk5("per_start", 4, 0, 1, 0);
    for (int i = 0; i < 11; i++) begin
      tick();
      // tc accompanies the reload to 4.
      chk5($sformatf("per%0d", i), per_q[i], per_q[i] == 4, 1, 0);
    end

    // ---- one-shot N=5
    start = 1'b1; oneshot = 1'b1;
    tick();
    start = 1'b0; oneshot = 1'b0;
    chk5("os_start", 4, 0, 1, 0);
    for (int i = 3; i >= 0; i--) begin
      tick();
      chk5($sformatf("os_q%0d", i), i, 0, 1, 0);
    end
    tick();
    chk5("os_expire", 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk5($sformatf("os_hold%0d", i), 0, 0, 0, 1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk5("os_restart", 4, 0, 1, 0);

    // ---- pause and priority (periodic, running from 4)
    tick(); tick();
    chk5("pr_at2", 2, 0, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk5($sformatf("pause%0d", i), 2, 0, 1, 0);
    end
    en = 1'b1; load = 1'b1; lv5 = 3'd7;
    tick();
    load = 1'b0;
    chk5("load_clamp", 4, 0, 1, 0);
    tick();
    chk5("after_load", 3, 0, 1, 0);
    // start and load together: start wins and re-samples mode (one-shot).
    start = 1'b1; load = 1'b1; lv5 = 3'd1; oneshot = 1'b1;
    tick();
    start = 1'b0; load = 1'b0; oneshot = 1'b0;
    chk5("start_vs_load", 4, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    chk5("sl_at0", 0, 0, 1, 0);
    tick();
    chk5("sl_oneshot", 0, 1, 0, 1);

    // ---- restart mid-count, then pause at 0
    start = 1'b1; oneshot = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk5("rs_at1", 1, 0, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk5("restart", 4, 0, 1, 0);
    tick();
    chk5("rs_next", 3, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    chk5("pz_at0", 0, 0, 1, 0);
    en = 1'b0;
    tick(); tick();
    chk5("pz_hold", 0, 0, 1, 0);
    en = 1'b1;
    tick();
    chk5("pz_resume", 4, 1, 1, 0);

    // ---- reset mid-count at q=2
    tick(); tick();
    chk5("rm_at2", 2, 0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk5("rst_run", 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk5($sformatf("idle%0d", i), 4, 0, 0, 0);
    end

    // ---- load in IDLE does not start counting
    load = 1'b1; lv5 = 3'd2;
    tick();
    load = 1'b0;
    chk5("idle_load", 2, 0, 0, 0);
    tick();
    chk5("idle_hold", 2, 0, 0, 0);

    // ---- reset from DONE
    start = 1'b1; oneshot = 1'b1;
    tick();
    start = 1'b0; oneshot = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk5("rd_done", 0, 1, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk5("rst_done", 4, 0, 0, 0);
    tick();
    chk5("rd_idle", 4, 0, 0, 0);

    // ---- boundary: N=2/WIDTH=1 and default N=4/WIDTH=2, periodic
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("n2_reset", 32'(q2), 32'd1);
    check("n4_reset", 32'(q4), 32'd3);
    start = 1'b1; oneshot = 1'b0;
    tick();
    start = 1'b0;
    check("n2_start", 32'(q2), 32'd1);
    check("n4_start", 32'(q4), 32'd3);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("n2_q%0d", i),  32'(q2),  32'(n2_q[i]));
      check($sformatf("n2_tc%0d", i), 32'(tc2), 32'(n2_q[i] == 1));
      check($sformatf("n4_q%0d", i),  32'(q4),  32'(n4_q[i]));
      check($sformatf("n4_tc%0d", i), 32'(tc4), 32'(n4_q[i] == 3));
      check($sformatf("n4_busy%0d", i), 32'(busy4), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
